// File: rtl/conv_pkg.sv
// Shared types and defaults for the 3x3 convolution frame sequencer.
// Imported by conv_tag_delay and conv_frame_sequencer.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    FLUSH
  } seq_state_t;

  localparam int DEF_IMG_W    = 64;
  localparam int DEF_IMG_H    = 64;
  localparam int DEF_K        = 3;
  localparam int DEF_PIPE_LAT = 4;
  localparam int DEF_CW       = 9;

  typedef logic [DEF_CW-1:0] coord_t;

  function automatic int out_dim(input int in_d, input int k);
    return in_d - k + 1;
  endfunction

endpackage

// File: rtl/conv_tag_delay.sv
// Fixed-depth shift line carrying {valid, row, col, last} alongside the
// conv core pipeline; synchronous clear wipes every stage.
module conv_tag_delay
  import conv_pkg::*;
#(
  parameter int DEPTH = DEF_PIPE_LAT,
  parameter int CW    = DEF_CW
) (
  input  logic          clk,
  input  logic          i_clr,
  input  logic          i_valid,
  input  logic [CW-1:0] i_row,
  input  logic [CW-1:0] i_col,
  input  logic          i_last,
  output logic          o_valid,
  output logic [CW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic          o_last
);

  logic [DEPTH-1:0]         r_valid;
  logic [DEPTH-1:0]         r_last;
  logic [DEPTH-1:0][CW-1:0] r_row;
  logic [DEPTH-1:0][CW-1:0] r_col;

  // shift tags one stage per cycle; clear drops everything in flight
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_valid <= '0;
      r_last  <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_last[0]  <= i_last;
      r_row[0]   <= i_row;
      r_col[0]   <= i_col;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_last[i]  <= r_last[i-1];
        r_row[i]   <= r_row[i-1];
        r_col[i]   <= r_col[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_last  = r_last[DEPTH-1];
  assign o_row   = r_row[DEPTH-1];
  assign o_col   = r_col[DEPTH-1];

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame controller for the pipelined 3x3 convolution core: load, issue, tag.
// Optional macro CONV_SEQ_STATS_EN adds the stall_cnt output.
module conv_frame_sequencer
  import conv_pkg::*;
#(
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int K        = DEF_K,
  parameter int PIPE_LAT = DEF_PIPE_LAT,
  parameter int CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          pix_valid,
  output logic          pix_ready,
  output logic          ld_en,
  output logic [CW-1:0] ld_row,
  output logic [CW-1:0] ld_col,
  input  logic          hold,
  output logic          iss_en,
  output logic [CW-1:0] iss_row,
  output logic [CW-1:0] iss_col,
  output logic          res_valid,
  output logic [CW-1:0] res_row,
  output logic [CW-1:0] res_col,
  output logic          res_last,
  output logic          busy,
  output logic          frame_done
`ifdef CONV_SEQ_STATS_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  localparam int OUT_W = out_dim(IMG_W, K);
  localparam int OUT_H = out_dim(IMG_H, K);
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NOUT  = OUT_W * OUT_H;
  localparam int LCW   = $clog2(NPIX + 1);
  localparam int ICW   = $clog2(NOUT + 1);

  seq_state_t r_state;
  seq_state_t w_next;

  logic [LCW-1:0] r_ld_cnt;
  logic [ICW-1:0] r_iss_cnt;
  logic [CW-1:0]  r_ld_row;
  logic [CW-1:0]  r_ld_col;
  logic [CW-1:0]  r_iss_row;
  logic [CW-1:0]  r_iss_col;
  logic           r_pix_ready;
  logic           r_frame_done;

  logic           w_start;
  logic           w_active;
  logic [LCW-1:0] w_thresh;
  logic           w_win;
  logic           w_iss;
  logic           w_ld;
  logic           w_last_ld;
  logic           w_last_iss;
  logic           w_end_xy;
  logic           w_clr;

  assign w_start  = (r_state == IDLE) & start & ~abort;
  assign w_active = (r_state == LOAD) | (r_state == DRAIN);

  // index of the bottom-right pixel of the current issue window
  assign w_thresh = (LCW'(r_iss_row) + LCW'(K - 1)) * LCW'(IMG_W)
                  + LCW'(r_iss_col) + LCW'(K - 1);

  assign w_win = w_active
               & (r_iss_cnt < ICW'(NOUT))
               & (r_ld_cnt > w_thresh);

  assign w_iss      = w_win & ~hold;
  assign w_ld       = pix_valid & r_pix_ready;
  assign w_last_ld  = w_ld & (r_ld_cnt == LCW'(NPIX - 1));
  assign w_last_iss = w_iss & (r_iss_cnt == ICW'(NOUT - 1));
  assign w_end_xy   = (r_iss_row == CW'(OUT_H - 1))
                    & (r_iss_col == CW'(OUT_W - 1));
  assign w_clr      = ~reset | abort;

  // state register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // next-state decode; abort returns to IDLE from anywhere
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (start)      w_next = LOAD;
      LOAD:  if (w_last_ld)  w_next = DRAIN;
      DRAIN: if (w_last_iss) w_next = FLUSH;
      FLUSH: if (res_last)   w_next = IDLE;
    endcase
    if (abort) w_next = IDLE;
  end

  // registered ready, high exactly while in LOAD
  always_ff @(posedge clk) begin
    if (!reset) r_pix_ready <= 1'b0;
    else        r_pix_ready <= (w_next == LOAD);
  end

  // completion pulse lands in the first IDLE cycle after FLUSH
  always_ff @(posedge clk) begin
    if (!reset) r_frame_done <= 1'b0;
    else        r_frame_done <= (r_state == FLUSH) & res_last & ~abort;
  end

  // load pointer and accepted-pixel count
  always_ff @(posedge clk) begin
    if (w_clr || w_start) begin
      r_ld_cnt <= '0;
      r_ld_row <= '0;
      r_ld_col <= '0;
    end else if (w_ld) begin
      r_ld_cnt <= r_ld_cnt + 1'b1;
      if (r_ld_col == CW'(IMG_W - 1)) begin
        r_ld_col <= '0;
        r_ld_row <= r_ld_row + 1'b1;
      end else begin
        r_ld_col <= r_ld_col + 1'b1;
      end
    end
  end

  // issue pointer and issued-result count
  always_ff @(posedge clk) begin
    if (w_clr || w_start) begin
      r_iss_cnt <= '0;
      r_iss_row <= '0;
      r_iss_col <= '0;
    end else if (w_iss) begin
      r_iss_cnt <= r_iss_cnt + 1'b1;
      if (r_iss_col == CW'(OUT_W - 1)) begin
        r_iss_col <= '0;
        r_iss_row <= r_iss_row + 1'b1;
      end else begin
        r_iss_col <= r_iss_col + 1'b1;
      end
    end
  end

  conv_tag_delay #(
    .DEPTH (PIPE_LAT),
    .CW    (CW)
  ) u_tag (
    .clk     (clk),
    .i_clr   (w_clr),
    .i_valid (w_iss),
    .i_row   (r_iss_row),
    .i_col   (r_iss_col),
    .i_last  (w_iss & w_end_xy),
    .o_valid (res_valid),
    .o_row   (res_row),
    .o_col   (res_col),
    .o_last  (res_last)
  );

  assign pix_ready  = r_pix_ready;
  assign ld_en      = w_ld;
  assign ld_row     = r_ld_row;
  assign ld_col     = r_ld_col;
  assign iss_en     = w_iss;
  assign iss_row    = r_iss_row;
  assign iss_col    = r_iss_col;
  assign busy       = (r_state != IDLE);
  assign frame_done = r_frame_done;

`ifdef CONV_SEQ_STATS_EN
  logic [15:0] r_stall_cnt;

  // saturating count of ready windows blocked by hold
  always_ff @(posedge clk) begin
    if (!reset)
      r_stall_cnt <= '0;
    else if (w_start)
      r_stall_cnt <= '0;
    else if (w_win && hold && r_stall_cnt != 16'hFFFF)
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Randomized self-checking bench for conv_frame_sequencer.
// Reference model tracks accepted/issued counts and an issue-tag queue.
module tb_conv_frame_sequencer;

  localparam int IW   = 64;
  localparam int IH   = 64;
  localparam int KK   = 3;
  localparam int LAT  = 4;
  localparam int CW   = 9;
  localparam int OW   = IW - KK + 1;
  localparam int OH   = IH - KK + 1;
  localparam int NPIX = IW * IH;
  localparam int NOUT = OW * OH;

  logic clk = 1'b0;
  logic reset, start, abort, pix_valid, hold;
  logic pix_ready, ld_en, iss_en, res_valid, res_last, busy, frame_done;
  logic [CW-1:0] ld_row, ld_col, iss_row, iss_col, res_row, res_col;
`ifdef CONV_SEQ_STATS_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  conv_frame_sequencer dut (
`ifdef CONV_SEQ_STATS_EN
    .stall_cnt  (stall_cnt),
`endif
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .ld_en      (ld_en),
    .ld_row     (ld_row),
    .ld_col     (ld_col),
    .hold       (hold),
    .iss_en     (iss_en),
    .iss_row    (iss_row),
    .iss_col    (iss_col),
    .res_valid  (res_valid),
    .res_row    (res_row),
    .res_col    (res_col),
    .res_last   (res_last),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic finish_tb();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      if (n_fail >= 200) finish_tb();
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int cyc;
    int r;
    int c;
    bit last;
  } tag_t;

  tag_t q[$];
  bit   m_init   = 0;
  bit   m_active = 0;
  bit   m_done   = 0;
  int   m_A      = 0;
  int   m_I      = 0;
  int   m_cyc    = 0;
  int   m_stall  = 0;

  function automatic bit exp_win();
    int r, c;
    r = m_I / OW;
    c = m_I % OW;
    return m_active && (m_I < NOUT) && (m_A > (r + KK - 1) * IW + c + KK - 1);
  endfunction

  function automatic bit exp_iss();
    return exp_win() && !hold;
  endfunction

  function automatic bit exp_pr();
    return m_active && (m_A < NPIX);
  endfunction

  function automatic bit exp_rv();
    if (q.size() == 0) return 1'b0;
    return (q[0].cyc + LAT == m_cyc);
  endfunction

  always @(posedge clk) begin : model
    bit isn, ld, rv, rl, was;
    tag_t t;
    if (!reset) begin
      m_init = 1; m_active = 0; m_A = 0; m_I = 0;
      q.delete(); m_done = 0; m_stall = 0;
    end else if (abort) begin
      m_active = 0; m_A = 0; m_I = 0; q.delete(); m_done = 0;
    end else begin
      isn = exp_iss();
      ld  = exp_pr() && pix_valid;
      rv  = exp_rv();
      rl  = 0;
      if (rv) rl = q[0].last;
      was = m_active;
      m_done = rl;
      if (exp_win() && hold && m_stall < 65535) m_stall++;
      if (rv) void'(q.pop_front());
      if (rl) m_active = 0;
      if (!was) begin
        if (start) begin
          m_active = 1; m_A = 0; m_I = 0; m_stall = 0;
        end
      end else begin
        if (ld) m_A++;
        if (isn) begin
          t.cyc  = m_cyc;
          t.r    = m_I / OW;
          t.c    = m_I % OW;
          t.last = (t.r == OH - 1) && (t.c == OW - 1);
          q.push_back(t);
          m_I++;
        end
      end
    end
    m_cyc++;
  end

  // ---------------- per-frame observations ----------------
  int acc_cyc [NPIX];
  int acc_r   [NPIX];
  int acc_c   [NPIX];
  int iss_r   [NOUT];
  int iss_c   [NOUT];
  int f_acc, f_res, f_done, f_iss, first_iss_cyc, last_r, last_c;

  // compare DUT against the model away from the active edge
  always @(negedge clk) begin : cmp
    int idx;
    bit ok;
    if (m_init) begin
      chk("busy", busy, m_active);
      chk("pix_ready", pix_ready, exp_pr());
      chk("ld_en", ld_en, exp_pr() && pix_valid);
      chk("ld_pos", ld_row * 1000 + ld_col, (m_A / IW) * 1000 + m_A % IW);
      chk("iss_en", iss_en, exp_iss());
      chk("iss_pos", iss_row * 1000 + iss_col, (m_I / OW) * 1000 + m_I % OW);
      chk("res_valid", res_valid, exp_rv());
      if (exp_rv())
        chk("res_tag", res_row * 10000 + res_col * 10 + res_last,
            q[0].r * 10000 + q[0].c * 10 + int'(q[0].last));
      chk("frame_done", frame_done, m_done);
`ifdef CONV_SEQ_STATS_EN
      chk("stall_cnt", stall_cnt, m_stall);
`endif
      if (iss_en === 1'b1) begin
        idx = (int'(iss_row) + 2) * IW + int'(iss_col) + 2;
        ok = 0;
        if (idx < f_acc) ok = (acc_cyc[idx] < m_cyc);
        chk("iss_after_window", ok, 1);
        if (f_iss < NOUT) begin
          iss_r[f_iss] = iss_row;
          iss_c[f_iss] = iss_col;
        end
        if (f_iss == 0) first_iss_cyc = m_cyc;
        f_iss++;
      end
      if (ld_en === 1'b1) begin
        if (f_acc < NPIX) begin
          acc_cyc[f_acc] = m_cyc;
          acc_r[f_acc]   = ld_row;
          acc_c[f_acc]   = ld_col;
        end
        f_acc++;
      end
      if (res_valid === 1'b1) begin
        f_res++;
        if (res_last === 1'b1) begin
          last_r = res_row;
          last_c = res_col;
        end
      end
      if (frame_done === 1'b1) f_done++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic clr_obs();
    f_acc = 0; f_res = 0; f_done = 0; f_iss = 0;
    first_iss_cyc = -1; last_r = -1; last_c = -1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    step();
    clr_obs();
    start = 1;
    step();
    start = 0;
  endtask

  // vm: 0 continuous, 1 toggle, 2 random; hm: 0 none, 1 ten-cycle, 2 random
  task automatic run_frame(input int vm, input int hm);
    int k = 0;
    int hc = 0;
    bit hdone = 0;
    start_frame();
    while (m_active && k < 40000) begin
      case (vm)
        0: pix_valid = 1;
        1: pix_valid = k[0];
        default: pix_valid = ($urandom_range(0, 3) != 0);
      endcase
      if (hm == 1) begin
        if (hc > 0) begin
          hold = 1; hc--;
        end else if (!hdone && m_I == 630) begin
          hold = 1; hc = 9; hdone = 1;
        end else begin
          hold = 0;
        end
      end else if (hm == 2) begin
        hold = ($urandom_range(0, 7) == 0);
      end else begin
        hold = 0;
      end
      step();
      k++;
    end
    chk("frame_end_in_budget", k < 40000, 1);
    pix_valid = 0;
    hold = 0;
    repeat (3) step();
  endtask

  task automatic check_full(input string nm);
    chk({nm, "_accepts"}, f_acc, NPIX);
    chk({nm, "_results"}, f_res, 3844);
    chk({nm, "_done_pulses"}, f_done, 1);
    chk({nm, "_last_pos"}, last_r * 1000 + last_c, 61061);
    chk({nm, "_idle_after"}, busy, 0);
  endtask

  initial begin
    int k;
    reset = 0; start = 0; abort = 0; pix_valid = 0; hold = 0;
    clr_obs();
    repeat (3) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk("reset_flags",
        {busy, pix_ready, ld_en, iss_en, res_valid, res_last, frame_done}, 0);
    chk("reset_pos", ld_row | ld_col | iss_row | iss_col | res_row | res_col, 0);

    // continuous stream, no hold
    run_frame(0, 0);
    check_full("cont");
    chk("first_iss_after_131st", first_iss_cyc - acc_cyc[130], 1);
    chk("first_iss_pos", iss_r[0] * 1000 + iss_c[0], 0);
    chk("ld_pos_63", acc_r[63] * 1000 + acc_c[63], 63);
    chk("ld_wrap_64", acc_r[64] * 1000 + acc_c[64], 1000);
    chk("iss_pos_61", iss_r[61] * 1000 + iss_c[61], 61);
    chk("iss_wrap_62", iss_r[62] * 1000 + iss_c[62], 1000);
    chk("iss_count", f_iss, 3844);

    // pix_valid toggling every other cycle
    run_frame(1, 0);
    check_full("toggle");

    // ten-cycle hold in the middle of LOAD
    run_frame(0, 1);
    check_full("hold");
`ifdef CONV_SEQ_STATS_EN
    chk("hold_stall_cnt", stall_cnt, 10);
`endif

    // abort after the 2000th accept
    start_frame();
    pix_valid = 1;
    k = 0;
    while (m_A < 2000 && k < 5000) begin
      step();
      k++;
    end
    chk("abort_reached_2000", m_A == 2000, 1);
    abort = 1;
    step();
    abort = 0;
    f_res = 0;
    f_done = 0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_pix_ready", pix_ready, 0);
    repeat (30) step();
    pix_valid = 0;
    chk("abort_no_res", f_res, 0);
    chk("abort_no_done", f_done, 0);
    run_frame(0, 0);
    check_full("post_abort");

    // reset while in FLUSH
    start_frame();
    pix_valid = 1;
    k = 0;
    while (m_I < NOUT && k < 20000) begin
      step();
      k++;
    end
    pix_valid = 0;
    chk("flush_reached", q.size() > 0, 1);
    reset = 0;
    step();
    reset = 1;
    f_res = 0;
    f_done = 0;
    @(negedge clk);
    chk("flush_rst_flags",
        {busy, pix_ready, ld_en, iss_en, res_valid, res_last, frame_done}, 0);
    chk("flush_rst_pos",
        ld_row | ld_col | iss_row | iss_col | res_row | res_col, 0);
    repeat (20) step();
    chk("flush_rst_no_res", f_res, 0);
    chk("flush_rst_no_done", f_done, 0);

    // random valid and hold
    run_frame(2, 2);
    check_full("random");

    finish_tb();
  end

endmodule

// File: doc/conv_frame_sequencer.md
Name: conv_frame_sequencer

Overview:
Frame-level controller for the pipelined 3x3 Laplacian convolution core. It accepts an RGB pixel stream through a valid/ready handshake and generates the core's load enable and write coordinates. It issues one output-pixel computation per cycle once that pixel's 3x3 window is fully loaded, and tags each result with its row/col and last flag after the pipeline latency. It sits between the pixel source and the conv core, and tells the result sink when a frame is complete.

Parameters:
IMG_W, 64, input frame width in pixels
IMG_H, 64, input frame height in pixels
K, 3, kernel size; output dimensions are (IMG_W-K+1) x (IMG_H-K+1)
PIPE_LAT, 4, cycles from iss_en to the matching core result
CW, 9, coordinate width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low
start  in  1  begin frame; honoured only in IDLE
abort  in  1  cancel current frame
pix_valid  in  1  source has a pixel
pix_ready  out  1  sequencer accepts a pixel
ld_en  out  1  core write enable (= pix_valid & pix_ready)
ld_row, ld_col  out  CW each  core write coordinate
hold  in  1  downstream stall; blocks new issues
iss_en  out  1  core compute-issue strobe
iss_row, iss_col  out  CW each  output coordinate being issued
res_valid  out  1  core result valid
res_row, res_col  out  CW each  coordinate of the result
res_last  out  1  result is (OUT_H-1, OUT_W-1)
busy  out  1  state is not IDLE
frame_done  out  1  one-cycle completion pulse

Behaviour:
- Reset (reset=0 at posedge) forces IDLE, clears all counters and the delay line, and drives every output to 0. It overrides everything, including mid-frame.
- abort has the next priority. It returns the FSM to IDLE and clears pointers and the delay line; no frame_done and no further res_valid are produced.
- States:
  - IDLE: start moves to LOAD.
  - LOAD: moves to DRAIN once IMG_W*IMG_H pixels have been accepted.
  - DRAIN: moves to FLUSH on the last issue.
  - FLUSH: moves to IDLE on the cycle res_last is high.
- frame_done is registered, so it is high in the first IDLE cycle after FLUSH. A start in that same cycle is accepted.
- pix_ready is high only in LOAD. It is registered and independent of hold.
- Load pointer (ld_row, ld_col) advances on each accept. ld_col wraps from IMG_W-1 to 0 and ld_row increments on the wrap.
- ld_cnt counts pixels accepted in completed cycles. Width is clog2(IMG_W*IMG_H+1).
- iss_en is combinational from registers, high when all of the following hold:
  - state is LOAD or DRAIN;
  - issued count < OUT_W*OUT_H;
  - hold = 0;
  - ld_cnt > (iss_row+K-1)*IMG_W + iss_col + K-1.
- ld_cnt is not bypassed: a pixel written this cycle never enables a same-cycle issue.
- Issue pointer wraps iss_col from OUT_W-1 to 0 with iss_row+1. Load and issue may happen in the same cycle.
- A PIPE_LAT-deep shift line carries {valid, row, col, last}. res_* equal the iss_* values exactly PIPE_LAT cycles earlier. Results cannot be stalled: hold only gates issue.
- Arithmetic is unsigned. The threshold product is computed at ld_cnt width, and the comparison never overflows for the defaults.

Optional Feature:
CONV_SEQ_STATS_EN
- Defined: adds output stall_cnt [15:0]. It counts cycles in LOAD/DRAIN where the window condition is met but hold=1. It saturates at 16'hFFFF, clears on accepted start, and resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package conv_pkg:
  - seq_state_t enum {IDLE, LOAD, DRAIN, FLUSH};
  - coord_t = logic [CW-1:0];
  - default IMG_W/IMG_H/K/PIPE_LAT constants;
  - function out_dim(in, k) = in-k+1.
- One sub-module, conv_tag_delay: parameterised-depth shift line for {valid, row, col, last} with synchronous clear on reset/abort.

Test Plan:
- Continuous pix_valid, hold=0, default params:
  - 4096 accepts; first iss_en (0,0) in the cycle after the 131st accept;
  - 3844 res_valid, each PIPE_LAT=4 cycles after its issue;
  - res_last at (61,61); exactly one frame_done, and busy=0 afterwards.
- Wrap checks: ld_col 63->0 with ld_row 0->1; iss_col 61->0 with iss_row+1; res coordinates mirror the issue sequence exactly.
- pix_valid toggling every other cycle: every iss (r,c) occurs strictly after the cycle accepting (r+2,c+2); still 3844 results total.
- hold=1 for 10 cycles mid-LOAD:
  - iss_en stays 0 while pix_ready stays 1;
  - issue resumes at the same coordinate, no gaps or duplicates;
  - with CONV_SEQ_STATS_EN, stall_cnt=10.
- abort after the 2000th accept: next cycle busy=0, pix_ready=0, res_valid=0 forever, no frame_done. A subsequent start completes a clean 3844-result frame.
- reset=0 during FLUSH: all outputs 0 next cycle, state IDLE, and no residual res_valid after reset is released.
